bound_flasher_16: RTL and testbench
===================================

# bound_flasher_16

Sixteen-lamp bound-flasher controller. A single `flick` pulse starts a fixed multi-phase sweep that lights and extinguishes `led_state` as a thermometer bar, one lamp per clock. At the kickback points, `flick` can send the bar back down. It is a standalone leaf block with registered outputs that drive the lamp bank directly.

## Interface
- Parameters: none. Width (16) and kickback points (lamp 5, lamp 10) are fixed.
- `clk`  in  1  system clock, rising edge active.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flick`  in  1  start/kickback request, sampled on rising `clk`, level-sensitive.
- `led_state`  out  16  lamp vector, bit k = lamp k. Always a thermometer code (ones contiguous from bit 0), registered.

## Operation
- Steps:
  - ON step: `led_state <= {led_state[14:0],1'b1}`.
  - OFF step: `led_state <= led_state >> 1`.
- States and per-edge behaviour:
  - INIT: hold `led_state` = 0.
    - If `flick`=1, go to UP5 and perform an ON step, so `led_state` = 0x0001.
  - UP5: if `led_state[5]`=1, go to DN0 with an OFF step; else ON step.
  - DN0: if `led_state`=0, go to UP10 with an ON step; else OFF step.
  - UP10:
    - If `led_state[10]`=1, go to DN5 with an OFF step.
    - Else if `led_state`=0x003F and `flick`=1 (kickback), go to DN0 with an OFF step.
    - Else ON step.
  - DN5: if `led_state`=0x001F, go to UP15 with an ON step; else OFF step.
  - UP15:
    - If `led_state[15]`=1, go to DN0F with an OFF step.
    - Else if (`led_state`=0x003F or 0x07FF) and `flick`=1 (kickback), go to DN5 with an OFF step.
    - Else ON step.
  - DN0F: if `led_state`=0, go to INIT and hold 0; else OFF step.
- `flick` is ignored in UP5, DN0, DN5 and DN0F, and at every non-kickback value.
- A sustained `flick` at a kickback point repeats the kickback each time that point is reached.
- Next state and `led_state` are a pure function of current state, `led_state` and `flick`. No other storage.

## Timing
- Reset: while `rst_n`=0, `led_state`=0x0000 and state=INIT, asynchronously. Assertion mid-sweep aborts immediately.
- Recovery: first active edge after `rst_n` rises evaluates INIT.
- Latency: `led_state` changes on the same edge that samples `flick`=1 in INIT (0x0000 → 0x0001).
- Peaks and floors: each peak (0x003F, 0x07FF, 0xFFFF) and floor (0x0000, 0x001F) is displayed for exactly one cycle, except 0x0000 in INIT.
- Sweep length without kickback, counted from the start edge: 6 up, 6 down, 11 up, 6 down, 11 up, 16 down. That is 56 edges; 0x0000 is reached on edge 56, and INIT is entered on edge 57.
- A new start is possible only from INIT. `flick` held high through the end of the sweep restarts on the edge after INIT is entered.

## Configuration
- `BOUND_FLASHER_KICKBACK_EN`
  - Defined: kickback transitions in UP10 and UP15 are active, as specified above.
  - Undefined: kickback logic is removed, `flick` is honoured only in INIT, and every sweep is the fixed 56-step sequence.
- Reset and all other behaviour are identical in both builds.

## Test plan
- Reset:
  - Assert `rst_n`=0 with `flick`=1 → `led_state`=0x0000 throughout.
  - Release `rst_n` with `flick`=0 → stays 0x0000.
- Basic sweep: one-cycle `flick` pulse in INIT → sequence 0x0001, 0x0003, …, 0x003F, 0x001F, …, 0x0000, 0x0001, …, 0x07FF, 0x03FF, …, 0x001F, 0x003F, …, 0xFFFF, 0x7FFF, …, 0x0000, then holds 0 (56 transitions).
- Kickback at lamp 5 (KICKBACK_EN): `flick`=1 while UP10 shows 0x003F → next 0x001F, down to 0x0000, then restarts UP10 at 0x0001.
- Kickback at lamp 10 (KICKBACK_EN): `flick`=1 while UP15 shows 0x07FF → next 0x03FF, down to 0x001F, then climbs again.
  - Without the macro the same stimulus gives 0x0FFF.
- Ignored flick: `flick` held high through UP5/DN0 → sequence identical to the basic sweep.
- Async reset mid-sweep: `rst_n` low between edges while `led_state`=0x01FF → immediately 0x0000 and INIT. Next `flick` restarts at 0x0001.

Source files
------------

// File: rtl/bound_flasher_16_if.sv
// Lamp-bank interface for the sixteen-lamp bound flasher.
// The requester drives flick; the controller drives the lamp vector back.
interface bound_flasher_16_if;
  // No valid/ready pair: flick is a level sampled on every rising clk, and
  // led_state is a registered level that is valid every cycle after reset.
  logic        flick;
  logic [15:0] led_state;

  modport master (
    output flick,
    input  led_state
  );

  modport slave (
    input  flick,
    output led_state
  );
endinterface

// File: rtl/bound_flasher_16.sv
// Sixteen-lamp bound flasher: flick starts a multi-phase thermometer sweep.
// Optional feature macro: BOUND_FLASHER_KICKBACK_EN (flick kickback at lamps 5 and 10).
module bound_flasher_16 (
  input  logic                     clk,
  input  logic                     rst_n,
  bound_flasher_16_if.slave        bus,
  output logic [2:0]               o_dbg_state
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_UP5  = 3'd1,
    S_DN0  = 3'd2,
    S_UP10 = 3'd3,
    S_DN5  = 3'd4,
    S_UP15 = 3'd5,
    S_DN0F = 3'd6
  } state_t;

  state_t      r_state;
  logic [15:0] r_led;
  logic [15:0] w_on_step;
  logic [15:0] w_off_step;

  assign w_on_step  = {r_led[14:0], 1'b1};
  assign w_off_step = {1'b0, r_led[15:1]};

`ifdef BOUND_FLASHER_KICKBACK_EN
  logic w_kick_lo;
  logic w_kick_hi;
  assign w_kick_lo = (r_led == 16'h003F);
  assign w_kick_hi = (r_led == 16'h07FF);
`endif

  // Each climb ends when the top lamp of its phase is lit; each fall ends on its floor value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_led   <= 16'h0000;
    end else begin
      case (r_state)
        S_INIT: begin
          if (bus.flick) begin
            r_state <= S_UP5;
            r_led   <= w_on_step;
          end
        end
        S_UP5: begin
          if (r_led[5]) begin
            r_state <= S_DN0;
            r_led   <= w_off_step;
          end else begin
            r_led   <= w_on_step;
          end
        end
        S_DN0: begin
          if (r_led == 16'h0000) begin
            r_state <= S_UP10;
            r_led   <= w_on_step;
          end else begin
            r_led   <= w_off_step;
          end
        end
        S_UP10: begin
          if (r_led[10]) begin
            r_state <= S_DN5;
            r_led   <= w_off_step;
          end
`ifdef BOUND_FLASHER_KICKBACK_EN
          else if (w_kick_lo && bus.flick) begin
            r_state <= S_DN0;
            r_led   <= w_off_step;
          end
`endif
          else begin
            r_led   <= w_on_step;
          end
        end
        S_DN5: begin
          if (r_led == 16'h001F) begin
            r_state <= S_UP15;
            r_led   <= w_on_step;
          end else begin
            r_led   <= w_off_step;
          end
        end
        S_UP15: begin
          if (r_led[15]) begin
            r_state <= S_DN0F;
            r_led   <= w_off_step;
          end
`ifdef BOUND_FLASHER_KICKBACK_EN
          else if ((w_kick_lo || w_kick_hi) && bus.flick) begin
            r_state <= S_DN5;
            r_led   <= w_off_step;
          end
`endif
          else begin
            r_led   <= w_on_step;
          end
        end
        S_DN0F: begin
          if (r_led == 16'h0000) begin
            r_state <= S_INIT;
          end else begin
            r_led   <= w_off_step;
          end
        end
        default: begin
          r_state <= S_INIT;
          r_led   <= 16'h0000;
        end
      endcase
    end
  end

  assign bus.led_state = r_led;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_bound_flasher_16.sv
// Randomized bench for bound_flasher_16 against a lamp-count/phase-table reference model.
module tb_bound_flasher_16;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         n_vec;
  int         n_err;

  bound_flasher_16_if bus ();

  bound_flasher_16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Model tracks the number of lit lamps and the index of the current sweep
  // phase; even phases climb, odd phases fall, -1 means idle.
  int seg_tgt [6] = '{6, 0, 11, 5, 16, 0};
  int m_seg;
  int m_n;

  function automatic void model_reset();
    m_seg = -1;
    m_n   = 0;
  endfunction

  function automatic void model_step(input logic f);
    if (m_seg < 0) begin
      if (f) begin
        m_seg = 0;
        m_n   = 1;
      end
    end else if ((m_seg % 2) == 0) begin
      if (m_n == seg_tgt[m_seg]) begin
        m_seg = m_seg + 1;
        m_n   = m_n - 1;
      end
`ifdef BOUND_FLASHER_KICKBACK_EN
      else if (f && ((m_seg == 2 && m_n == 6) ||
                     (m_seg == 4 && (m_n == 6 || m_n == 11)))) begin
        m_seg = m_seg - 1;
        m_n   = m_n - 1;
      end
`endif
      else begin
        m_n = m_n + 1;
      end
    end else begin
      if (m_n == seg_tgt[m_seg]) begin
        if (m_seg == 5) begin
          m_seg = -1;
        end else begin
          m_seg = m_seg + 1;
          m_n   = m_n + 1;
        end
      end else begin
        m_n = m_n - 1;
      end
    end
  endfunction

  function automatic logic [15:0] exp_led();
    logic [31:0] v;
    v = (32'd1 << m_n) - 32'd1;
    return v[15:0];
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (m_seg=%0d m_n=%0d) at %0t",
               tag, obs, exp, m_seg, m_n, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock edge: advance the model with the sampled inputs, then compare 1ns later.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(bus.flick);
    #1;
    check("led", bus.led_state, exp_led());
    check("idle", {15'b0, dbg_state == 3'd0}, {15'b0, m_seg < 0});
  endtask

  task automatic run_quiet(input int cycles);
    bus.flick = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit k1;
    bit k2;
    bit found;
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst_n     = 1'b0;
    bus.flick = 1'b1;

    // Reset with flick asserted, then release with flick low.
    for (int i = 0; i < 4; i++) step();
    rst_n     = 1'b1;
    bus.flick = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Basic sweep from a single-cycle pulse.
    bus.flick = 1'b1;
    step();
    check("start", bus.led_state, 16'h0001);
    run_quiet(62);
    check("end_idle", bus.led_state, 16'h0000);

    // Directed kickbacks: once at 0x003F in UP10, once at 0x07FF in UP15.
    k1 = 1'b0;
    k2 = 1'b0;
    bus.flick = 1'b1;
    step();
    for (int i = 0; i < 120; i++) begin
      bus.flick = 1'b0;
      if (m_seg == 2 && m_n == 6 && !k1) begin
        bus.flick = 1'b1;
        k1 = 1'b1;
      end else if (m_seg == 4 && m_n == 11 && !k2) begin
        bus.flick = 1'b1;
        k2 = 1'b1;
      end
      step();
    end
    run_quiet(40);

    // flick held high: ignored in the first phases, repeated kickbacks where enabled.
    bus.flick = 1'b1;
    for (int i = 0; i < 150; i++) step();
    run_quiet(120);

    // Async reset mid-sweep at 0x01FF.
    bus.flick = 1'b1;
    step();
    bus.flick = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (m_seg == 2 && m_n == 9) found = 1'b1;
    end
    check("reach_1ff", {15'b0, found}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_led", bus.led_state, 16'h0000);
    check("async_state", {13'b0, dbg_state}, 16'h0000);
    step();
    rst_n     = 1'b1;
    bus.flick = 1'b1;
    step();
    check("restart", bus.led_state, 16'h0001);
    run_quiet(20);

    // Random flick activity.
    for (int i = 0; i < 3000; i++) begin
      bus.flick = ($urandom_range(0, 3) == 0);
      step();
    end
    run_quiet(120);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
